// File: rtl/player_input_hub.sv
// Multi-player mouse input hub: per-bit synchronisers, stability filter with clamp,
// frame-latched coordinates and a round-robin click-event FIFO. Macro: INPUT_HUB_RELEASE_EVT_EN.

module player_input_hub_filt #(
   parameter int unsigned W             = 1,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned MAX_VAL       = 0,
   parameter bit          CLAMP_EN      = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_in,
   output logic [W-1:0] stable_out
);
   localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);

   logic [W-1:0]   sync_q [SYNC_STAGES];
   logic [W-1:0]   sync_d [SYNC_STAGES];
   logic [W-1:0]   last_q, last_d;
   logic [W-1:0]   stable_q, stable_d;
   logic [W-1:0]   clamped;
   logic [SCW-1:0] cnt_q, cnt_d;

   // Count how long the synced word has been unchanged; a torn bus never persists.
   always_comb begin
      sync_d[0] = d_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
      last_d = last_q;
      cnt_d  = cnt_q;
      if (sync_q[SYNC_STAGES-1] != last_q) begin
         last_d = sync_q[SYNC_STAGES-1];
         cnt_d  = SCW'(1);
      end else if (cnt_q != SCW'(STABLE_CYCLES)) begin
         cnt_d = cnt_q + SCW'(1);
      end
   end

   generate
      if (CLAMP_EN) begin : g_clamp
         assign clamped = (last_d > W'(MAX_VAL)) ? W'(MAX_VAL) : last_d;
      end else begin : g_noclamp
         assign clamped = last_d;
      end
   endgenerate

   always_comb stable_d = (cnt_d == SCW'(STABLE_CYCLES)) ? clamped : stable_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         last_q   <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         sync_q   <= sync_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_out = stable_q;
endmodule

module player_input_hub #(
   parameter int unsigned NUM_PLAYERS   = 2,
   parameter int unsigned CANVAS_WIDTH  = 360,
   parameter int unsigned CANVAS_HEIGHT = 720,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH    = 4,
   localparam int unsigned XW = $clog2(CANVAS_WIDTH),
   localparam int unsigned YW = $clog2(CANVAS_HEIGHT),
   localparam int unsigned PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                      clk_pixel,
   input  logic                      sys_rst,
   input  logic                      new_frame,
   input  logic [NUM_PLAYERS*XW-1:0] mouse_x_in,
   input  logic [NUM_PLAYERS*YW-1:0] mouse_y_in,
   input  logic [NUM_PLAYERS-1:0]    click_in,
   output logic [NUM_PLAYERS*XW-1:0] mouse_x_out,
   output logic [NUM_PLAYERS*YW-1:0] mouse_y_out,
   output logic [NUM_PLAYERS-1:0]    click_out,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [PW-1:0]             evt_player,
   output logic [XW-1:0]             evt_x,
   output logic [YW-1:0]             evt_y,
   output logic                      evt_release,
   output logic [7:0]                evt_dropped
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic [PW-1:0] player;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic          rel;
   } evt_t;

   logic [XW-1:0]          stab_x [NUM_PLAYERS];
   logic [YW-1:0]          stab_y [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0] stab_c;

   generate
      for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ch
         player_input_hub_filt #(
            .W(XW), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_VAL(CANVAS_WIDTH - 1), .CLAMP_EN(1'b1)
         ) u_fx (
            .clk(clk_pixel), .rst(sys_rst),
            .d_in(mouse_x_in[g*XW +: XW]), .stable_out(stab_x[g])
         );
         player_input_hub_filt #(
            .W(YW), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_VAL(CANVAS_HEIGHT - 1), .CLAMP_EN(1'b1)
         ) u_fy (
            .clk(clk_pixel), .rst(sys_rst),
            .d_in(mouse_y_in[g*YW +: YW]), .stable_out(stab_y[g])
         );
         player_input_hub_filt #(
            .W(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_VAL(1), .CLAMP_EN(1'b0)
         ) u_fc (
            .clk(clk_pixel), .rst(sys_rst),
            .d_in(click_in[g]), .stable_out(stab_c[g])
         );
      end
   endgenerate

   logic [NUM_PLAYERS*XW-1:0] out_x_q, out_x_d;
   logic [NUM_PLAYERS*YW-1:0] out_y_q, out_y_d;
   logic [NUM_PLAYERS-1:0]    out_c_q, out_c_d;
   logic [NUM_PLAYERS-1:0]    click_prev_q, click_prev_d;
   logic [NUM_PLAYERS-1:0]    pending_q, pending_d;
   logic [XW-1:0]             ex_q [NUM_PLAYERS];
   logic [XW-1:0]             ex_d [NUM_PLAYERS];
   logic [YW-1:0]             ey_q [NUM_PLAYERS];
   logic [YW-1:0]             ey_d [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]    erel_q, erel_d;
   logic [PW-1:0]             rr_q, rr_d;
   evt_t                      mem_q [FIFO_DEPTH];
   evt_t                      mem_d [FIFO_DEPTH];
   logic [AW-1:0]             wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   evt_t                      head_q, head_d;
   logic                      valid_q, valid_d;
   logic [7:0]                drop_q, drop_d;

   logic [NUM_PLAYERS-1:0]    rise, fall;
   logic                      pop, push_ok, push, found;
   logic [PW-1:0]             gnt, cand;
   evt_t                      new_evt;

   always_comb begin
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      out_c_d      = out_c_q;
      pending_d    = pending_q;
      ex_d         = ex_q;
      ey_d         = ey_q;
      erel_d       = erel_q;
      rr_d         = rr_q;
      mem_d        = mem_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      drop_d       = drop_q;
      found        = 1'b0;
      gnt          = '0;
      cand         = '0;
      new_evt      = '0;
      click_prev_d = stab_c;

      if (new_frame) begin
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            out_x_d[i*XW +: XW] = stab_x[i];
            out_y_d[i*YW +: YW] = stab_y[i];
         end
         out_c_d = stab_c;
      end

      rise = stab_c & ~click_prev_q;
`ifdef INPUT_HUB_RELEASE_EVT_EN
      fall = ~stab_c & click_prev_q;
`else
      fall = '0;
`endif

      // Round-robin: first pending channel at or after rr_q.
      pop     = valid_q && evt_ready;
      push_ok = (cnt_q < CW'(FIFO_DEPTH)) || pop;
      for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
         cand = PW'((32'(rr_q) + k) % NUM_PLAYERS);
         if (!found && pending_q[cand]) begin
            found = 1'b1;
            gnt   = cand;
         end
      end
      push = found && push_ok;

      if (push) begin
         pending_d[gnt]  = 1'b0;
         rr_d            = PW'((32'(gnt) + 1) % NUM_PLAYERS);
         new_evt.player  = gnt;
         new_evt.x       = ex_q[gnt];
         new_evt.y       = ey_q[gnt];
         new_evt.rel     = erel_q[gnt];
         mem_d[wr_q]     = new_evt;
         wr_d            = wr_q + AW'(1);
      end

      // A new edge on a still-occupied slot is dropped; a slot freed this cycle accepts it.
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
         if (rise[i] || fall[i]) begin
            if (pending_q[i] && !(push && gnt == PW'(i))) begin
               if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
            end else begin
               pending_d[i] = 1'b1;
               ex_d[i]      = stab_x[i];
               ey_d[i]      = stab_y[i];
               erel_d[i]    = fall[i];
            end
         end
      end

      if (pop) rd_d = rd_q + AW'(1);
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      valid_d = (cnt_d != '0);
      head_d  = mem_d[rd_d];
   end

   always_ff @(posedge clk_pixel) begin
      if (sys_rst) begin
         out_x_q      <= '0;
         out_y_q      <= '0;
         out_c_q      <= '0;
         click_prev_q <= '0;
         pending_q    <= '0;
         for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
            ex_q[i] <= '0;
            ey_q[i] <= '0;
         end
         erel_q  <= '0;
         rr_q    <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
         drop_q  <= '0;
      end else begin
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         out_c_q      <= out_c_d;
         click_prev_q <= click_prev_d;
         pending_q    <= pending_d;
         ex_q         <= ex_d;
         ey_q         <= ey_d;
         erel_q       <= erel_d;
         rr_q         <= rr_d;
         mem_q        <= mem_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
         head_q       <= head_d;
         valid_q      <= valid_d;
         drop_q       <= drop_d;
      end
   end

   assign mouse_x_out = out_x_q;
   assign mouse_y_out = out_y_q;
   assign click_out   = out_c_q;
   assign evt_valid   = valid_q;
   assign evt_player  = head_q.player;
   assign evt_x       = head_q.x;
   assign evt_y       = head_q.y;
   assign evt_release = head_q.rel;
   assign evt_dropped = drop_q;
endmodule

// File: tb/tb_player_input_hub.sv
// Directed bench for player_input_hub (default build: press events only).

module tb_player_input_hub;
   localparam int unsigned N  = 2;
   localparam int unsigned XW = 9;
   localparam int unsigned YW = 10;

   logic            clk = 1'b0;
   logic            sys_rst;
   logic            new_frame;
   logic [N*XW-1:0] mx;
   logic [N*YW-1:0] my;
   logic [N-1:0]    mc;
   logic [N*XW-1:0] mxo;
   logic [N*YW-1:0] myo;
   logic [N-1:0]    mco;
   logic            evt_valid;
   logic            evt_ready;
   logic [0:0]      evt_player;
   logic [XW-1:0]   evt_x;
   logic [YW-1:0]   evt_y;
   logic            evt_release;
   logic [7:0]      evt_dropped;

   int n_vec = 0;
   int n_err = 0;
   int q_p[$], q_x[$], q_y[$], q_r[$];

   always #5 clk = ~clk;

   player_input_hub dut (
      .clk_pixel(clk), .sys_rst(sys_rst), .new_frame(new_frame),
      .mouse_x_in(mx), .mouse_y_in(my), .click_in(mc),
      .mouse_x_out(mxo), .mouse_y_out(myo), .click_out(mco),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_player(evt_player),
      .evt_x(evt_x), .evt_y(evt_y), .evt_release(evt_release),
      .evt_dropped(evt_dropped)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame();
      new_frame = 1'b1;
      tick(1);
      new_frame = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      tick(3);
      sys_rst = 1'b0;
   endtask

   task automatic set_xy(input int ch, input int x, input int y);
      mx[ch*XW +: XW] = XW'(x);
      my[ch*YW +: YW] = YW'(y);
   endtask

   // Accept for max_cyc cycles, logging each head seen while valid.
   task automatic drain(input int max_cyc, output int n);
      q_p.delete(); q_x.delete(); q_y.delete(); q_r.delete();
      n = 0;
      evt_ready = 1'b1;
      for (int c = 0; c < max_cyc; c++) begin
         if (evt_valid) begin
            q_p.push_back(int'(evt_player));
            q_x.push_back(int'(evt_x));
            q_y.push_back(int'(evt_y));
            q_r.push_back(int'(evt_release));
            n++;
         end
         tick(1);
      end
      evt_ready = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int n, bad, p0, x0;
      sys_rst = 1'b1; new_frame = 1'b0; mx = '0; my = '0; mc = '0; evt_ready = 1'b0;
      tick(1);
      do_reset();
      check("rst_x_out", mxo, 0);
      check("rst_y_out", myo, 0);
      check("rst_click_out", mco, 0);
      check("rst_valid", evt_valid, 0);
      check("rst_dropped", evt_dropped, 0);

      // Coordinate only reaches the output on a frame after it has settled.
      set_xy(0, 100, 0);
      tick(2);
      pulse_frame();
      check("x_early_frame", mxo[0 +: XW], 0);
      tick(3);
      check("x_hold_no_frame", mxo[0 +: XW], 0);
      pulse_frame();
      check("x_after_frame", mxo[0 +: XW], 100);

      // Clamp on load.
      set_xy(1, 500, 1000);
      tick(8);
      pulse_frame();
      check("clamp_x_ch1", mxo[XW +: XW], 359);
      check("clamp_y_ch1", myo[YW +: YW], 719);
      check("ch0_x_kept", mxo[0 +: XW], 100);

      // Toggling bus is never accepted; only the final settled value.
      bad = 0;
      new_frame = 1'b1;
      for (int i = 0; i < 20; i++) begin
         mx[0 +: XW] = (i % 2 == 0) ? XW'(5) : XW'(250);
         tick(1);
         if (mxo[0 +: XW] != 100) bad++;
      end
      mx[0 +: XW] = XW'(42);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (mxo[0 +: XW] != 100 && mxo[0 +: XW] != 42) bad++;
      end
      new_frame = 1'b0;
      check("toggle_bad_values", bad, 0);
      check("toggle_final", mxo[0 +: XW], 42);

      // Single press with ready high.
      set_xy(0, 10, 20);
      tick(8);
      mc[0] = 1'b1;
      drain(15, n);
      check("press_count", n, 1);
      if (n >= 1) begin
         check("press_player", q_p[0], 0);
         check("press_x", q_x[0], 10);
         check("press_y", q_y[0], 20);
         check("press_rel", q_r[0], 0);
      end
      mc[0] = 1'b0;
      tick(8);

      // Simultaneous presses after reset: ch0 then ch1.
      do_reset();
      mc = 2'b11;
      tick(12);
      check("both_valid", evt_valid, 1);
      p0 = int'(evt_player); x0 = int'(evt_x);
      tick(1);
      check("hold_player", evt_player, p0);
      check("hold_x", evt_x, x0);
      drain(10, n);
      check("both_count", n, 2);
      if (n == 2) begin
         check("both_first", q_p[0], 0);
         check("both_second", q_p[1], 1);
      end
      mc = 2'b00;
      tick(8);
      mc[0] = 1'b1;
      tick(12);
      drain(10, n);
      check("single_ch0_count", n, 1);
      mc = 2'b00;
      tick(8);
      mc = 2'b11;
      tick(12);
      drain(10, n);
      check("rr_count", n, 2);
      if (n == 2) begin
         check("rr_first", q_p[0], 1);
         check("rr_second", q_p[1], 0);
      end
      mc = 2'b00;
      tick(8);

      // Six presses with no consumer: 4 in FIFO, 1 pending, 1 dropped.
      for (int i = 0; i < 6; i++) begin
         mx[0 +: XW] = XW'(i * 10 + 11);
         tick(6);
         mc[0] = 1'b1;
         tick(6);
         mc[0] = 1'b0;
         tick(6);
      end
      check("full_valid", evt_valid, 1);
      check("full_dropped", evt_dropped, 1);
      drain(20, n);
      check("full_drain_count", n, 5);
      for (int i = 0; i < 5; i++)
         if (i < n) check($sformatf("full_order_x%0d", i), q_x[i], i * 10 + 11);
      check("full_empty_after", evt_valid, 0);

      // Reset with a queued event and click held: queue discarded, one fresh press.
      mc[0] = 1'b1;
      tick(12);
      check("pre_rst_valid", evt_valid, 1);
      do_reset();
      check("midrst_valid", evt_valid, 0);
      check("midrst_dropped", evt_dropped, 0);
      check("midrst_x_out", mxo, 0);
      tick(15);
      drain(5, n);
      check("held_click_count", n, 1);
      if (n == 1) check("held_click_player", q_p[0], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
